aes_access_arbiter: RTL and testbench
=====================================

Name: aes_access_arbiter

Overview:
- Shares the single AES peripheral register port (AESBase 0x1010_0000, length 0x1000) among NumReq crossbar masters.
- Each transaction is a single-beat register access.
- Performs round-robin arbitration, an address range check and a response-timeout watchdog.
- Sits between the crossbar's AES slave port (after AXI-to-register conversion) and the AES wrapper; exactly one transaction is in flight at a time.

Parameters:
- NumReq, 3, number of requesters (matches crossbar NrSlaves).
- AddrWidth, 64, request address width.
- DataWidth, 32, register data width.
- BaseAddr, 64'h1010_0000, AES window base.
- WinLength, 64'h1000, AES window length in bytes.
- TimeoutCycles, 256, maximum cycles from peripheral issue to response; must be ≥2.

Ports:
- clk_i in 1: clock.
- rst_ni in 1: asynchronous active-low reset.
- req_i in NumReq: per-requester request.
- we_i in NumReq: per-requester write enable.
- addr_i in NumReq x AddrWidth: per-requester byte address.
- wdata_i in NumReq x DataWidth: per-requester write data.
- gnt_o out NumReq: one-hot grant, request accepted.
- rvalid_o out NumReq: one-hot response valid.
- err_o out NumReq: error qualifier, valid with rvalid_o.
- rdata_o out DataWidth: shared read data, valid with rvalid_o.
- per_req_o out 1: request to AES.
- per_we_o out 1: write enable to AES.
- per_addr_o out 12: word-aligned offset into window (addr - BaseAddr, low 12 bits).
- per_wdata_o out DataWidth: write data to AES.
- per_gnt_i in 1: AES accepted request.
- per_rvalid_i in 1: AES response valid.
- per_rdata_i in DataWidth: AES read data.
- busy_o out 1: state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer 0, timeout counter 0, latched request fields 0.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_i is set, pick the winner w = first set bit searching upward from (last+1) mod NumReq; at reset last = NumReq-1, so requester 0 has first priority.
  - gnt_o[w]=1 combinationally in that cycle. Latch we/addr/wdata and w, then set last=w.
  - In range (BaseAddr ≤ addr < BaseAddr+WinLength) → ISSUE; otherwise → RESP with err.
  - Requesters may change or drop fields after gnt.
- ISSUE: per_req_o=1 with latched fields; hold stable until per_gnt_i. On per_gnt_i → WAIT; if per_rvalid_i is also high that cycle, capture it and go straight to RESP.
- WAIT: on per_rvalid_i, register per_rdata_i → RESP.
- RESP: rvalid_o[w]=1 for exactly one cycle, with rdata_o (0 on error) and err_o[w]; then → IDLE. A new grant is possible on the following cycle, not in RESP.
- Minimum latency: gnt at cycle 0, per_req_o at cycle 1, rvalid_o at cycle 3 with per_gnt at cycle 1 and per_rvalid at cycle 2. Zero-wait path (per_gnt and per_rvalid both at cycle 1): rvalid_o at cycle 2.
- Timeout:
  - Counter clears on entry to ISSUE and increments each ISSUE/WAIT cycle.
  - At count TimeoutCycles-1 without a response: drop per_req_o and go to RESP with err=1, rdata 0.
  - A per_rvalid_i arriving in IDLE/RESP is ignored. A per_gnt_i outside ISSUE is ignored.
  - Counter width is clog2(TimeoutCycles)+1; it saturates, never wraps.
- Address arithmetic: 64-bit compare without overflow (WinLength+BaseAddr fits in 64 bits). addr[1:0] is ignored; per_addr_o[1:0]=0.
- Simultaneous requests: exactly one grant per IDLE cycle; losers hold req_i and are served in round-robin order, with no starvation (worst case NumReq-1 transactions ahead).
- Reset mid-operation: immediate return to IDLE, outputs 0, the in-flight transaction is discarded with no response.

Optional Feature:
- Macro AES_ARB_KEYLOCK_EN.
- When defined: writes from any requester other than 0 (M-mode hart) to key offsets 0x014–0x028 (key0) or 0x050–0x07C (key1/key2) are not forwarded. The block goes IDLE→RESP with err=1. Reads and non-key writes are unaffected.
- When undefined: all in-range accesses are forwarded, and the key-offset compare logic is absent.

Decomposition:
- Package aes_arb_pkg holds:
  - state_e enum {IDLE, ISSUE, WAIT, RESP};
  - key-offset localparams (Key0Lo=12'h014, Key0Hi=12'h028, Key12Lo=12'h050, Key12Hi=12'h07C);
  - the timeout-counter width function.
- One sub-module, aes_arb_rr_pick: combinational round-robin picker with inputs req vector and last index, outputs one-hot winner, index and valid.

Test Plan:
- Single read: req_i=3'b001, addr 0x1010_0010; per_gnt at cycle 1, per_rvalid at cycle 2 with data 0xDEADBEEF → rvalid_o=3'b001 at cycle 3, rdata_o=0xDEADBEEF, err_o=0, per_addr_o=0x010.
- Contention: req_i=3'b111 held throughout, zero-wait peripheral → grant order 0,1,2,0; each rvalid_o exactly 2 cycles after its grant.
- Out of range: requester 1 accesses 0x1010_1000 → gnt at cycle 0, rvalid_o[1]=1 with err_o[1]=1 at cycle 1, per_req_o never asserted.
- Timeout: per_gnt at cycle 1, per_rvalid never asserted, TimeoutCycles=8 → per_req_o drops, rvalid_o with err=1 after 8 ISSUE/WAIT cycles, rdata_o=0. A late per_rvalid in IDLE produces no rvalid_o.
- Reset in WAIT: rst_ni low for 1 cycle → all outputs 0, busy_o=0. The next request from requester 0 is granted first.
- With AES_ARB_KEYLOCK_EN: requester 2 writes 0x1010_0014 → err=1, no per_req_o. Requester 0 writing the same address is forwarded with per_addr_o=0x014.

Source files
------------

// File: rtl/aes_arb_pkg.sv
// Shared definitions for the AES register-port arbiter.
//   state_e     : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   Key*Lo/Hi   : word offsets of the key registers inside the AES window,
//                 inclusive bounds, used only when AES_ARB_KEYLOCK_EN is defined
//   cnt_width() : width of the response-timeout counter
//   idx_width() : width of a requester index
package aes_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [11:0] Key0Lo  = 12'h014;
  localparam logic [11:0] Key0Hi  = 12'h028;
  localparam logic [11:0] Key12Lo = 12'h050;
  localparam logic [11:0] Key12Hi = 12'h07C;

  // One spare bit above clog2 so the counter can saturate without wrapping.
  function automatic int cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles) + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_arb_rr_pick.sv
// Combinational round-robin picker.
// The search starts at (last+1) mod NumReq and wraps upward; the first set
// request bit wins.
//   req    in  NumReq : request vector
//   last   in  IdxW   : index of the previous winner
//   onehot out NumReq : one-hot winner (all zero when no request)
//   idx    out IdxW   : winner index
//   valid  out 1      : at least one request is set
module aes_arb_rr_pick
  import aes_arb_pkg::*;
#(
  parameter int NumReq = 3,
  parameter int IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last,
  output logic [NumReq-1:0] onehot,
  output logic [IdxW-1:0]   idx,
  output logic              valid
);

  always_comb begin
    int cand;
    cand   = 0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    // i runs 1..NumReq so the previous winner is checked last.
    for (int i = 1; i <= NumReq; i++) begin
      cand = (int'(last) + i) % NumReq;
      if (!valid && req[IdxW'(cand)]) begin
        valid                = 1'b1;
        idx                  = IdxW'(cand);
        onehot[IdxW'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_access_arbiter.sv
// Shares the single AES register port among NumReq masters. One single-beat
// transaction is in flight at a time: round-robin grant, window range check,
// and a watchdog that answers with an error if the peripheral stalls.
//
// Handshake: a requester's access is accepted in the cycle gnt_o[i] is high
// (IDLE only); its fields are latched then and may change afterwards. Exactly
// one cycle of rvalid_o[i] later returns rdata_o/err_o. Toward the peripheral,
// per_req_o and its fields stay stable until the cycle per_gnt_i is seen;
// per_rvalid_i is honoured in that same cycle or any later ISSUE/WAIT cycle.
//
// Optional build macro: AES_ARB_KEYLOCK_EN -- writes by requesters other than
// 0 to the key register offsets are rejected with err instead of forwarded.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   req_i/we_i/addr_i/wdata_i     per-requester request fields
//   gnt_o, rvalid_o, err_o        per-requester one-hot grant / response
//   rdata_o                       shared read data (0 on error)
//   per_req_o, per_we_o,
//   per_addr_o, per_wdata_o       request to AES (addr = word offset in window)
//   per_gnt_i, per_rvalid_i,
//   per_rdata_i                   AES handshake and read data
//   busy_o                        FSM not IDLE
module aes_access_arbiter
  import aes_arb_pkg::*;
#(
  parameter int                   NumReq        = 3,
  parameter int                   AddrWidth     = 64,
  parameter int                   DataWidth     = 32,
  parameter logic [AddrWidth-1:0] BaseAddr      = 64'h1010_0000,
  parameter logic [AddrWidth-1:0] WinLength     = 64'h1000,
  // Must be at least 2.
  parameter int                   TimeoutCycles = 256
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq-1:0]                   we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
  output logic [NumReq-1:0]                   gnt_o,
  output logic [NumReq-1:0]                   rvalid_o,
  output logic [NumReq-1:0]                   err_o,
  output logic [DataWidth-1:0]                rdata_o,
  output logic                                per_req_o,
  output logic                                per_we_o,
  output logic [11:0]                         per_addr_o,
  output logic [DataWidth-1:0]                per_wdata_o,
  input  logic                                per_gnt_i,
  input  logic                                per_rvalid_i,
  input  logic [DataWidth-1:0]                per_rdata_i,
  output logic                                busy_o
);

  localparam int              IdxW    = idx_width(NumReq);
  localparam int              CntW    = cnt_width(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  state_e                 state_q;
  logic [IdxW-1:0]        last_q;
  logic [IdxW-1:0]        idx_q;
  logic                   we_q;
  logic [11:0]            addr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [DataWidth-1:0]   rdata_q;
  logic                   err_q;
  logic [CntW-1:0]        cnt_q;

  logic [NumReq-1:0]      pick_oh;
  logic [IdxW-1:0]        pick_idx;
  logic                   pick_valid;

  logic                   sel_we;
  logic [AddrWidth-1:0]   sel_addr;
  logic [DataWidth-1:0]   sel_wdata;
  logic [AddrWidth-1:0]   off_full;
  logic [11:0]            sel_off;
  logic                   in_range;
  logic                   key_block;
  logic                   timeout;
  logic [CntW-1:0]        cnt_next;
  logic [NumReq-1:0]      idx_oh;

  aes_arb_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_pick (
    .req    (req_i),
    .last   (last_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign sel_we    = we_i[pick_idx];
  assign sel_addr  = addr_i[pick_idx];
  assign sel_wdata = wdata_i[pick_idx];

  // Compare the offset against the length rather than the address against
  // BaseAddr+WinLength; the subtraction cannot underflow once addr >= base.
  assign off_full = sel_addr - BaseAddr;
  assign in_range = (sel_addr >= BaseAddr) && (off_full < WinLength);
  assign sel_off  = {off_full[11:2], 2'b00};

`ifdef AES_ARB_KEYLOCK_EN
  assign key_block = sel_we && (pick_idx != '0) &&
                     (((sel_off >= Key0Lo)  && (sel_off <= Key0Hi)) ||
                      ((sel_off >= Key12Lo) && (sel_off <= Key12Hi)));
`else
  assign key_block = 1'b0;
`endif

  assign timeout  = (cnt_q >= CntLast);
  assign cnt_next = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  assign idx_oh   = NumReq'(1) << idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= IdxW'(NumReq - 1);
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            idx_q   <= pick_idx;
            last_q  <= pick_idx;
            we_q    <= sel_we;
            addr_q  <= sel_off;
            wdata_q <= sel_wdata;
            rdata_q <= '0;
            cnt_q   <= '0;
            if (in_range && !key_block) begin
              err_q   <= 1'b0;
              state_q <= ISSUE;
            end else begin
              err_q   <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        ISSUE: begin
          cnt_q <= cnt_next;
          // A response in the final cycle still wins over the watchdog.
          if (per_gnt_i && per_rvalid_i) begin
            rdata_q <= per_rdata_i;
            state_q <= RESP;
          end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= RESP;
          end else if (per_gnt_i) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_next;
          if (per_rvalid_i) begin
            rdata_q <= per_rdata_i;
            state_q <= RESP;
          end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = '0;
    // Grant is combinational from req_i, so hold it off while in reset.
    if (state_q == IDLE && rst_ni) begin
      gnt_o = pick_oh;
    end
    if (state_q == RESP) begin
      rvalid_o = idx_oh;
      err_o    = err_q ? idx_oh : '0;
      rdata_o  = rdata_q;
    end
  end

  // Peripheral fields are zeroed outside ISSUE so the AES port is quiet
  // whenever no request is presented.
  assign per_req_o   = (state_q == ISSUE);
  assign per_we_o    = per_req_o && we_q;
  assign per_addr_o  = per_req_o ? addr_q  : '0;
  assign per_wdata_o = per_req_o ? wdata_q : '0;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_access_arbiter.sv
// Directed bench for aes_access_arbiter (TimeoutCycles overridden to 8).
// Compile with +define+AES_ARB_KEYLOCK_EN to exercise the key lock.
module tb_aes_access_arbiter;

  localparam int NumReq = 3;
  localparam int AW     = 64;
  localparam int DW     = 32;
  localparam int TO     = 8;

  logic                       clk_i = 1'b0;
  logic                       rst_ni;
  logic [NumReq-1:0]          req_i, we_i;
  logic [NumReq-1:0][AW-1:0]  addr_i;
  logic [NumReq-1:0][DW-1:0]  wdata_i;
  logic [NumReq-1:0]          gnt_o, rvalid_o, err_o;
  logic [DW-1:0]              rdata_o, per_wdata_o, per_rdata_i;
  logic                       per_req_o, per_we_o, per_gnt_i, per_rvalid_i, busy_o;
  logic [11:0]                per_addr_o;

  int n_vec = 0;
  int n_err = 0;

  // Clock / reset block
  always #5 clk_i = ~clk_i;

  aes_access_arbiter #(
    .NumReq        (NumReq),
    .AddrWidth     (AW),
    .DataWidth     (DW),
    .BaseAddr      (64'h1010_0000),
    .WinLength     (64'h1000),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .err_o        (err_o),
    .rdata_o      (rdata_o),
    .per_req_o    (per_req_o),
    .per_we_o     (per_we_o),
    .per_addr_o   (per_addr_o),
    .per_wdata_o  (per_wdata_o),
    .per_gnt_i    (per_gnt_i),
    .per_rvalid_i (per_rvalid_i),
    .per_rdata_i  (per_rdata_i),
    .busy_o       (busy_o)
  );

  // Scoreboard check
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    req_i        = '0;
    we_i         = '0;
    addr_i       = '0;
    wdata_i      = '0;
    per_gnt_i    = 1'b0;
    per_rvalid_i = 1'b0;
    per_rdata_i  = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},     gnt_o,     '0);
    check({tag, "_rvalid"},  rvalid_o,  '0);
    check({tag, "_err"},     err_o,     '0);
    check({tag, "_rdata"},   rdata_o,   '0);
    check({tag, "_per_req"}, per_req_o, '0);
    check({tag, "_per_we"},  per_we_o,  '0);
    check({tag, "_per_addr"},per_addr_o,'0);
    check({tag, "_busy"},    busy_o,    '0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  // Access rejected before reaching AES: grant now, error response next cycle.
  task automatic reject_access(input string tag, input int r, input logic we,
                               input logic [63:0] a);
    logic [2:0] oh;
    oh        = 3'(3'b001 << r);
    req_i     = oh;
    we_i[r]   = we;
    addr_i[r] = a;
    #1;
    check({tag, "_gnt"}, gnt_o, oh);
    tick();
    req_i = '0;
    we_i  = '0;
    #1;
    check({tag, "_rvalid"},  rvalid_o,  oh);
    check({tag, "_err"},     err_o,     oh);
    check({tag, "_rdata"},   rdata_o,   '0);
    check({tag, "_per_req"}, per_req_o, 1'b0);
    tick();
  endtask

  // Watchdog on the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [2:0]  exp_oh;
    logic [11:0] exp_addr [3];
    exp_addr[0] = 12'h000;
    exp_addr[1] = 12'h104;
    exp_addr[2] = 12'hFFC;

    // Reset values
    rst_ni = 1'b0;
    clear_inputs();
    #2;
    check_quiet("rst");
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    // Single read with one wait cycle: rvalid at cycle 3
    req_i     = 3'b001;
    addr_i[0] = 64'h1010_0010;
    #1;
    check("rd_gnt", gnt_o, 3'b001);
    tick();
    req_i     = '0;
    addr_i[0] = '0;
    per_gnt_i = 1'b1;
    #1;
    check("rd_per_req",  per_req_o,  1'b1);
    check("rd_per_addr", per_addr_o, 12'h010);
    check("rd_per_we",   per_we_o,   1'b0);
    check("rd_busy",     busy_o,     1'b1);
    tick();
    per_gnt_i    = 1'b0;
    per_rvalid_i = 1'b1;
    per_rdata_i  = 32'hDEAD_BEEF;
    #1;
    check("rd_wait_rvalid", rvalid_o,  '0);
    check("rd_wait_per_req",per_req_o, 1'b0);
    tick();
    per_rvalid_i = 1'b0;
    #1;
    check("rd_rvalid", rvalid_o, 3'b001);
    check("rd_rdata",  rdata_o,  32'hDEAD_BEEF);
    check("rd_err",    err_o,    3'b000);
    tick();
    #1;
    check("rd_done_busy",   busy_o,   1'b0);
    check("rd_done_rvalid", rvalid_o, '0);

    // Contention, zero-wait peripheral: order 0,1,2,0 from reset
    do_reset();
    req_i        = 3'b111;
    addr_i[0]    = 64'h1010_0000;
    addr_i[1]    = 64'h1010_0107;
    addr_i[2]    = 64'h1010_0FFC;
    per_gnt_i    = 1'b1;
    per_rvalid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_oh      = 3'(3'b001 << (k % 3));
      per_rdata_i = 32'hC0DE_0000 + 32'(k);
      #1;
      check("cont_gnt", gnt_o, exp_oh);
      tick();
      #1;
      check("cont_per_req",  per_req_o,  1'b1);
      check("cont_per_addr", per_addr_o, exp_addr[k % 3]);
      check("cont_early",    rvalid_o,   '0);
      check("cont_issue_gnt",gnt_o,      '0);
      tick();
      #1;
      check("cont_rvalid",   rvalid_o, exp_oh);
      check("cont_rdata",    rdata_o,  32'hC0DE_0000 + 32'(k));
      check("cont_err",      err_o,    '0);
      check("cont_resp_gnt", gnt_o,    '0);
      tick();
    end
    req_i        = '0;
    per_gnt_i    = 1'b0;
    per_rvalid_i = 1'b0;

    // Out of range: one past the window end, and just below the base
    reject_access("oor_hi", 1, 1'b0, 64'h1010_1000);
    reject_access("oor_lo", 2, 1'b0, 64'h100F_FFFC);

    // Timeout: gnt at cycle 1, no response; error at cycle 9
    per_rdata_i = 32'hFFFF_FFFF;
    req_i       = 3'b001;
    addr_i[0]   = 64'h1010_0020;
    #1;
    check("to_gnt", gnt_o, 3'b001);
    tick();
    req_i     = '0;
    per_gnt_i = 1'b1;
    #1;
    check("to_per_req", per_req_o, 1'b1);
    tick();
    per_gnt_i = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      #1;
      check("to_wait_rvalid", rvalid_o,  '0);
      check("to_wait_busy",   busy_o,    1'b1);
      check("to_wait_per_req",per_req_o, 1'b0);
      tick();
    end
    #1;
    check("to_rvalid",  rvalid_o,  3'b001);
    check("to_err",     err_o,     3'b001);
    check("to_rdata",   rdata_o,   '0);
    check("to_per_req", per_req_o, 1'b0);
    tick();
    per_rvalid_i = 1'b1;
    #1;
    check("late_rvalid_idle", rvalid_o, '0);
    check("late_busy",        busy_o,   1'b0);
    tick();
    #1;
    check("late_rvalid_next", rvalid_o, '0);
    per_rvalid_i = 1'b0;
    tick();

    // Reset while in WAIT; afterwards requester 0 has priority again
    req_i     = 3'b001;
    addr_i[0] = 64'h1010_0030;
    #1;
    check("rw_gnt", gnt_o, 3'b001);
    tick();
    req_i     = '0;
    per_gnt_i = 1'b1;
    tick();
    per_gnt_i = 1'b0;
    #1;
    check("rw_busy_wait", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    check_quiet("rw_in_reset");
    tick();
    rst_ni    = 1'b1;
    req_i     = 3'b011;
    addr_i[0] = 64'h1010_0040;
    addr_i[1] = 64'h1010_0044;
    #1;
    check("rw_first_gnt", gnt_o, 3'b001);
    tick();
    req_i        = '0;
    per_gnt_i    = 1'b1;
    per_rvalid_i = 1'b1;
    per_rdata_i  = 32'h0000_600D;
    #1;
    check("rw_per_addr", per_addr_o, 12'h040);
    tick();
    per_gnt_i    = 1'b0;
    per_rvalid_i = 1'b0;
    #1;
    check("rw_rvalid", rvalid_o, 3'b001);
    check("rw_rdata",  rdata_o,  32'h0000_600D);
    tick();

    // Key register write by requester 2
`ifdef AES_ARB_KEYLOCK_EN
    reject_access("kl_r2", 2, 1'b1, 64'h1010_0014);
`else
    req_i      = 3'b100;
    we_i       = 3'b100;
    addr_i[2]  = 64'h1010_0014;
    wdata_i[2] = 32'h1234_5678;
    #1;
    check("kw2_gnt", gnt_o, 3'b100);
    tick();
    req_i        = '0;
    we_i         = '0;
    per_gnt_i    = 1'b1;
    per_rvalid_i = 1'b1;
    #1;
    check("kw2_per_req",   per_req_o,   1'b1);
    check("kw2_per_addr",  per_addr_o,  12'h014);
    check("kw2_per_wdata", per_wdata_o, 32'h1234_5678);
    tick();
    per_gnt_i    = 1'b0;
    per_rvalid_i = 1'b0;
    #1;
    check("kw2_rvalid", rvalid_o, 3'b100);
    check("kw2_err",    err_o,    3'b000);
    tick();
`endif

    // Key register write by requester 0 is always forwarded
    req_i      = 3'b001;
    we_i       = 3'b001;
    addr_i[0]  = 64'h1010_0014;
    wdata_i[0] = 32'hA5A5_5A5A;
    #1;
    check("kw0_gnt", gnt_o, 3'b001);
    tick();
    req_i        = '0;
    we_i         = '0;
    per_gnt_i    = 1'b1;
    per_rvalid_i = 1'b1;
    per_rdata_i  = '0;
    #1;
    check("kw0_per_req",   per_req_o,   1'b1);
    check("kw0_per_we",    per_we_o,    1'b1);
    check("kw0_per_addr",  per_addr_o,  12'h014);
    check("kw0_per_wdata", per_wdata_o, 32'hA5A5_5A5A);
    tick();
    per_gnt_i    = 1'b0;
    per_rvalid_i = 1'b0;
    #1;
    check("kw0_rvalid", rvalid_o, 3'b001);
    check("kw0_err",    err_o,    3'b000);
    tick();

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
